// File: rtl/fpu_port_pkg.sv
// Shared types and constants for the FPU port master: state encoding, beat/word widths
// and the canonical quiet NaN returned when a beat handshake times out.
package fpu_port_pkg;

  localparam int BEAT_W = 16;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A_HI,
    SEND_A_LO,
    SEND_B_HI,
    SEND_B_LO,
    RECV_Z_HI,
    RECV_Z_LO,
    RESP
  } state_t;

endpackage

// File: rtl/fpu_port_timer.sv
// Per-beat watchdog: counts cycles spent waiting on one handshake and flags expiry
// on the cycle whose edge would bring the count up to TIMEOUT_CYCLES (0 disables it).
module fpu_port_timer #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam bit          ARMED = (TIMEOUT_CYCLES != 0);

  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (enable)  count <= count + 16'd1;
  end

  assign expired = ARMED && enable && (count == LAST);

endmodule

// File: rtl/fpu_port_master.sv
// Splits each 32-bit operand pair into 16-bit strobe/ack beats for the FPU core,
// reassembles the 16-bit result beats and returns them through a valid/ready response.
module fpu_port_master
  import fpu_port_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] req_a,
  input  logic [WORD_W-1:0] req_b,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [BEAT_W-1:0] output_a,
  output logic              output_a_stb,
  input  logic              output_a_ack,
  output logic [BEAT_W-1:0] output_b,
  output logic              output_b_stb,
  input  logic              output_b_ack,
  input  logic [BEAT_W-1:0] input_z,
  input  logic              input_z_stb,
  output logic              input_z_ack,
  output logic [WORD_W-1:0] resp_z,
  output logic              resp_err,
  output logic              resp_valid,
  input  logic              resp_ready
);

  state_t            state, state_nxt;
  logic [WORD_W-1:0] a_reg, b_reg, z_reg;
  logic              err_reg;
  logic              xfer, expired, timeout, beat_active, timer_clear;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A completed beat always beats a timer expiry landing on the same edge.
  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    unique case (state)
      IDLE:      if (req_valid) state_nxt = SEND_A_HI;
      SEND_A_HI: begin xfer = output_a_ack; if (xfer) state_nxt = SEND_A_LO; end
      SEND_A_LO: begin xfer = output_a_ack; if (xfer) state_nxt = SEND_B_HI; end
      SEND_B_HI: begin xfer = output_b_ack; if (xfer) state_nxt = SEND_B_LO; end
      SEND_B_LO: begin xfer = output_b_ack; if (xfer) state_nxt = RECV_Z_HI; end
      RECV_Z_HI: begin xfer = input_z_stb;  if (xfer) state_nxt = RECV_Z_LO; end
      RECV_Z_LO: begin xfer = input_z_stb;  if (xfer) state_nxt = RESP;      end
      RESP:      if (resp_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    timeout = expired && !xfer;
    if (timeout) state_nxt = RESP;
  end

  assign beat_active = (state != IDLE) && (state != RESP);
  assign timer_clear = xfer || (state_nxt != state);

  fpu_port_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (beat_active),
    .expired (expired)
  );

  // Data registers are deliberately left out of reset; rst only gates new captures.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && req_valid) begin
        a_reg   <= req_a;
        b_reg   <= req_b;
        err_reg <= 1'b0;
      end
      if (timeout) begin
        z_reg   <= QNAN;
        err_reg <= 1'b1;
      end else if (state == RECV_Z_HI && xfer) begin
        z_reg[31:16] <= input_z;
      end else if (state == RECV_Z_LO && xfer) begin
        z_reg[15:0] <= input_z;
      end
    end
  end

  always_comb begin
    req_ready    = (state == IDLE);
    output_a_stb = (state == SEND_A_HI) || (state == SEND_A_LO);
    output_b_stb = (state == SEND_B_HI) || (state == SEND_B_LO);
    input_z_ack  = (state == RECV_Z_HI) || (state == RECV_Z_LO);
    resp_valid   = (state == RESP);
    output_a     = '0;
    output_b     = '0;
    if (state == SEND_A_HI) output_a = a_reg[31:16];
    if (state == SEND_A_LO) output_a = a_reg[15:0];
    if (state == SEND_B_HI) output_b = b_reg[31:16];
    if (state == SEND_B_LO) output_b = b_reg[15:0];
    resp_z       = resp_valid ? z_reg : '0;
    resp_err     = resp_valid && err_reg;
  end

endmodule

// File: tb/tb_fpu_port_master.sv
// Randomised bench for fpu_port_master: a behavioural FPU core plus a queue-based
// model of expected beats and responses, with directed timeout and reset scenarios.
module tb_fpu_port_master;
  import fpu_port_pkg::*;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_a, req_b;
  logic        req_valid, req_ready;
  logic [15:0] output_a, output_b, input_z;
  logic        output_a_stb, output_a_ack, output_b_stb, output_b_ack;
  logic        input_z_stb, input_z_ack;
  logic [31:0] resp_z;
  logic        resp_err, resp_valid, resp_ready;

  always #5 clk = ~clk;

  fpu_port_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_valid(req_valid), .req_ready(req_ready),
    .output_a(output_a), .output_a_stb(output_a_stb), .output_a_ack(output_a_ack),
    .output_b(output_b), .output_b_stb(output_b_stb), .output_b_ack(output_b_ack),
    .input_z(input_z), .input_z_stb(input_z_stb), .input_z_ack(input_z_ack),
    .resp_z(resp_z), .resp_err(resp_err), .resp_valid(resp_valid), .resp_ready(resp_ready)
  );

  int checks = 0;
  int errors = 0;

  int a_delay = 0, b_delay = 0, z_delay = 0, r_delay = 0;
  bit b_block = 0, z_block_lo = 0, expect_timeout = 0;

  logic [15:0] exp_a[$], exp_b[$];
  logic [31:0] exp_z[$];
  bit          exp_err[$];
  int          resp_count = 0, z_beats = 0, issued = 0;
  logic [31:0] last_z;
  logic        last_err;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stand-in for the divider core: known quotients for the directed operands, a scramble otherwise.
  function automatic logic [31:0] core_result(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h3F800000 && b == 32'h40800000) return 32'h3E800000;
    if (a == 32'h40400000 && b == 32'h00000000) return 32'h7F800000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  initial begin : core_model
    bit          pa_stb = 0, pa_x = 0, pb_stb = 0, pb_x = 0, pz_x = 0, pr_v = 0, pr_x = 0;
    bit          after_resp = 0, a_x, b_x, z_x, r_x, blocked;
    logic [15:0] pa, pb, ev16;
    logic [31:0] pr, ev32, core_a, core_b;
    logic        per, everr;
    int          a_w = 0, b_w = 0, z_w = 0, r_w = 0, b_n = 0;
    logic [15:0] zq[$];
    output_a_ack = 0; output_b_ack = 0; input_z = 0; input_z_stb = 0; resp_ready = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_a.delete(); exp_b.delete(); exp_z.delete(); exp_err.delete(); zq.delete();
        pa_stb = 0; pa_x = 0; pb_stb = 0; pb_x = 0; pz_x = 0; pr_v = 0; pr_x = 0;
        after_resp = 0; b_n = 0;
      end else begin
        if (pa_stb && !pa_x && output_a_stb) checkOutput("a_hold", 32'(output_a), 32'(pa));
        if (pb_stb && !pb_x && output_b_stb) checkOutput("b_hold", 32'(output_b), 32'(pb));
        if (pr_v && !pr_x && resp_valid) begin
          checkOutput("z_hold", resp_z, pr);
          checkOutput("err_hold", 32'(resp_err), 32'(per));
        end
        if (after_resp) begin
          checkOutput("ready_after_resp", 32'(req_ready), 32'd1);
          checkOutput("valid_fall", 32'(resp_valid), 32'd0);
        end
        checkOutput("stb_overlap", 32'(output_a_stb & output_b_stb), 32'd0);
        checkOutput("resp_orphan", 32'(resp_valid && exp_z.size() == 0), 32'd0);

        if (req_valid && req_ready) begin
          exp_a.push_back(req_a[31:16]);
          exp_a.push_back(req_a[15:0]);
          if (expect_timeout) begin
            exp_z.push_back(QNAN);
            exp_err.push_back(1'b1);
          end else begin
            exp_b.push_back(req_b[31:16]);
            exp_b.push_back(req_b[15:0]);
            exp_z.push_back(core_result(req_a, req_b));
            exp_err.push_back(1'b0);
          end
        end

        a_x = output_a_stb && output_a_ack;
        if (a_x) begin
          ev16 = (exp_a.size() > 0) ? exp_a.pop_front() : ~output_a;
          checkOutput("a_beat", 32'(output_a), 32'(ev16));
          core_a = {core_a[15:0], output_a};
        end
        b_x = output_b_stb && output_b_ack;
        if (b_x) begin
          ev16 = (exp_b.size() > 0) ? exp_b.pop_front() : ~output_b;
          checkOutput("b_beat", 32'(output_b), 32'(ev16));
          core_b = {core_b[15:0], output_b};
          b_n++;
          if (b_n % 2 == 0) begin
            ev32 = core_result(core_a, core_b);
            zq.push_back(ev32[31:16]);
            zq.push_back(ev32[15:0]);
          end
        end
        z_x = input_z_stb && input_z_ack;
        if (z_x) begin
          z_beats++;
          void'(zq.pop_front());
        end
        r_x = resp_valid && resp_ready;
        if (r_x) begin
          ev32  = (exp_z.size() > 0) ? exp_z.pop_front() : ~resp_z;
          everr = (exp_err.size() > 0) ? exp_err.pop_front() : ~resp_err;
          checkOutput("resp_z", resp_z, ev32);
          checkOutput("resp_err", 32'(resp_err), 32'(everr));
          last_z = resp_z; last_err = resp_err; resp_count++;
        end
        after_resp = r_x;
        pa_stb = output_a_stb; pa_x = a_x; pa = output_a;
        pb_stb = output_b_stb; pb_x = b_x; pb = output_b;
        pz_x = z_x; pr_v = resp_valid; pr_x = r_x; pr = resp_z; per = resp_err;
      end

      @(posedge clk); #1;
      if (output_a_stb) begin
        if (!pa_stb || pa_x) a_w = 0; else a_w++;
        output_a_ack = (a_w >= a_delay);
      end else begin
        a_w = 0; output_a_ack = (a_delay == 0);
      end
      if (output_b_stb) begin
        if (!pb_stb || pb_x) b_w = 0; else b_w++;
        output_b_ack = !b_block && (b_w >= b_delay);
      end else begin
        b_w = 0; output_b_ack = !b_block && (b_delay == 0);
      end
      if (pz_x || zq.size() == 0) z_w = 0;
      if (zq.size() == 0) begin
        input_z_stb = 0; input_z = 16'($urandom);
      end else begin
        blocked     = z_block_lo && zq.size() == 1;
        input_z     = zq[0];
        input_z_stb = !blocked && (z_w >= z_delay);
        if (!input_z_stb) z_w++;
      end
      if (resp_valid) begin
        if (!pr_v || pr_x) r_w = 0; else r_w++;
        resp_ready = (r_w >= r_delay);
      end else begin
        r_w = 0; resp_ready = (r_delay == 0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    bit accepted = 0;
    req_a = a; req_b = b; req_valid = 1;
    for (int i = 0; i < 400 && !accepted; i++) begin
      @(negedge clk);
      accepted = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 0;
    issued++;
    checkOutput("req_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic waitResp(input int target);
    int n = 0;
    while (resp_count < target && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("resp_arrived", 32'(resp_count >= target), 32'd1);
  endtask

  task automatic setDelays(input int a, input int b, input int z, input int r);
    a_delay = a; b_delay = b; z_delay = z; r_delay = r;
  endtask

  initial begin : watchdog
    #5ms;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    int lat, k, n, zb;
    rst = 1; req_valid = 0; req_a = 0; req_b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_handshakes",
                32'({output_a_stb, output_b_stb, input_z_ack, resp_valid, resp_err}), 32'd0);
    @(posedge clk); #1;
    rst = 0;

    $display("[TB] nominal request and minimum latency");
    setDelays(0, 0, 0, 0);
    applyStimulus(32'h40C00000, 32'h40000000);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 50);
    checkOutput("latency", 32'(lat), 32'd7);
    waitResp(issued);
    checkOutput("nominal_z", last_z, 32'h40400000);
    checkOutput("nominal_err", 32'(last_err), 32'd0);

    $display("[TB] throttled core");
    setDelays(5, 5, 5, 3);
    applyStimulus(32'h40C00000, 32'h40000000);
    waitResp(issued);
    checkOutput("throttled_z", last_z, 32'h40400000);

    $display("[TB] back-to-back requests");
    setDelays(0, 0, 0, 0);
    applyStimulus(32'h3F800000, 32'h40800000);
    applyStimulus(32'h40400000, 32'h00000000);
    waitResp(issued - 1);
    checkOutput("b2b_first_z", last_z, 32'h3E800000);
    waitResp(issued);
    checkOutput("b2b_second_z", last_z, 32'h7F800000);

    $display("[TB] randomised traffic");
    for (int i = 0; i < 24; i++) begin
      setDelays($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
      applyStimulus($urandom, $urandom);
      if ($urandom_range(0, 1) == 1) waitResp(issued);
    end
    waitResp(issued);

    $display("[TB] B port timeout");
    setDelays(0, 0, 0, 0);
    b_block = 1; expect_timeout = 1;
    applyStimulus($urandom, $urandom);
    expect_timeout = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (!output_b_stb && k < 50);
    n = 0;
    while (output_b_stb && n < 100) begin n++; @(negedge clk); end
    checkOutput("timeout_stb_cycles", 32'(n), 32'(TIMEOUT));
    waitResp(issued);
    checkOutput("timeout_z", last_z, 32'h7FC00000);
    checkOutput("timeout_err", 32'(last_err), 32'd1);
    b_block = 0;
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;

    $display("[TB] reset during result low beat");
    z_block_lo = 1;
    zb = z_beats;
    applyStimulus($urandom, $urandom);
    issued--;
    k = 0;
    while (z_beats == zb && k < 200) begin @(posedge clk); #1; k++; end
    checkOutput("z_hi_seen", 32'(z_beats - zb), 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("stalled_in_z_lo", 32'(input_z_ack), 32'd1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    z_block_lo = 0;
    @(negedge clk);
    checkOutput("mid_rst_handshakes",
                32'({output_a_stb, output_b_stb, input_z_ack, resp_valid, resp_err}), 32'd0);
    checkOutput("mid_rst_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("rst_no_resp", 32'(resp_valid), 32'd0);
    end

    $display("[TB] recovery after reset");
    @(posedge clk); #1;
    resp_count = 0; issued = 0;
    applyStimulus(32'h40C00000, 32'h40000000);
    waitResp(issued);
    checkOutput("recovery_z", last_z, 32'h40400000);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_port_master.md
FPU_PORT_MASTER -- requirements
Module: fpu_port_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: maximum cycles allowed for any one beat handshake; 0 disables the timeout.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_a  input  32  IEEE-754 single operand A.
REQ-005 req_b  input  32  IEEE-754 single operand B.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-008 output_a  output  16  operand-A beat to the FPU core.
REQ-009 output_a_stb  output  1  output_a valid.
REQ-010 output_a_ack  input  1  core accepts A beat.
REQ-011 output_b, output_b_stb, output_b_ack: same as REQ-008 to REQ-010, for operand B.
REQ-012 input_z  input  16  result beat from the core.
REQ-013 input_z_stb  input  1  input_z valid.
REQ-014 input_z_ack  output  1  master ready to take a result beat.
REQ-015 resp_z  output  32  assembled result.
REQ-016 resp_err  output  1  result aborted by timeout.
REQ-017 resp_valid / resp_ready  output / input  1  response handshake.

Function
REQ-018 Beat transfer SHALL occur on a rising edge where stb and ack are both high; this rule applies to every beat, in both directions.
REQ-019 States and beat order SHALL be fixed: IDLE, SEND_A_HI, SEND_A_LO, SEND_B_HI, SEND_B_LO, RECV_Z_HI, RECV_Z_LO, RESP.
REQ-020 IDLE: req_ready=1 and all other outputs low. On accept, the block SHALL register req_a/req_b and enter SEND_A_HI, with output_a_stb high on the next cycle.
REQ-021 SEND_A_HI: output_a=a[31:16] and output_a_stb=1. On transfer, output_a SHALL become a[15:0] the next cycle, stb SHALL stay high, and the state SHALL go to SEND_A_LO.
REQ-022 SEND_A_LO: on transfer, output_a_stb SHALL drop and the state SHALL go to SEND_B_HI. SEND_B_HI and SEND_B_LO SHALL behave identically on the B port; after SEND_B_LO the state goes to RECV_Z_HI.
REQ-023 Only one stb SHALL be high at any time; A and B SHALL never overlap.
REQ-024 RECV_Z_HI: input_z_ack=1. On transfer, capture z[31:16] and go to RECV_Z_LO, keeping ack high.
REQ-025 RECV_Z_LO: on transfer, capture z[15:0], drop ack and go to RESP.
REQ-026 RESP: resp_valid=1, resp_z held stable and resp_err held stable. On resp_valid && resp_ready, go to IDLE; resp_valid SHALL fall the next cycle.
REQ-027 Back-to-back operation: req_ready SHALL be high on the cycle after the response handshake. A request arriving while not in IDLE SHALL be stalled, not dropped.
REQ-028 Minimum latency, request accept to resp_valid, SHALL be 7 cycles when every ack is already high.
REQ-029 Beat timer: 16-bit counter, cleared on every state entry and every transfer, incremented each cycle in SEND_*/RECV_*.
REQ-030 Timeout: when the beat timer reaches TIMEOUT_CYCLES (nonzero), the block SHALL drop stb/ack the same edge and enter RESP with resp_err=1 and resp_z=32'h7FC00000.
REQ-031 After a timeout the core side is desynchronised; only rst recovers it, and the block SHALL still accept new requests.
REQ-032 Ack and stb arriving on the same edge as timeout expiry: the transfer wins and the timer clears.
REQ-033 Data ports (output_a, output_b, resp_z) SHALL hold their values while the corresponding stb/valid is high and not yet acknowledged.

Reset
REQ-034 While rst=1, the block SHALL enter IDLE with req_ready=1 and output_a_stb, output_b_stb, input_z_ack, resp_valid, resp_err all 0. Data registers keep their values.
REQ-035 Reset mid-operation SHALL abandon the transaction immediately; no partial response SHALL be issued.

Structure
REQ-036 Shared package fpu_port_pkg SHALL hold: the state enumeration, BEAT_W=16, WORD_W=32, and QNAN=32'h7FC00000.
REQ-037 One sub-module, fpu_port_timer, SHALL implement the beat timer (clear, enable, expired outputs).

Verification
REQ-038 Nominal case: req_a=0x40C00000, req_b=0x40000000, core model returns 0x40400000 → beats A 0x40C0,0x0000 and B 0x4000,0x0000; resp_z=0x40400000, resp_err=0.
REQ-039 Throttled core: acks held low 5 cycles per beat, resp_ready low 3 cycles → same beat order, no duplicated or lost beat, data stable while waiting.
REQ-040 Back-to-back: two requests 1.0/4.0 then 3.0/0.0 → responses 0x3E800000 then 0x7F800000, delivered in order.
REQ-041 Timeout: TIMEOUT_CYCLES=8, output_b_ack never asserted → stb drops after 8 cycles in SEND_B_HI; resp_err=1, resp_z=0x7FC00000.
REQ-042 Reset during RECV_Z_LO → all handshake outputs 0 on the next edge, IDLE, no resp_valid pulse.
